// File: rtl/uart_fifo_if.sv
// TileLink-UL channel pair (A request, D response) carrying MMIO accesses to the console UART.
interface uart_fifo_if;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_opcode;
  logic [2:0]  a_param;
  logic [2:0]  a_size;
  logic [3:0]  a_source;
  logic [31:0] a_address;
  logic [7:0]  a_mask;
  logic [63:0] a_data;

  logic        d_valid;
  logic        d_ready;
  logic [2:0]  d_opcode;
  logic [1:0]  d_param;
  logic [2:0]  d_size;
  logic [3:0]  d_source;
  logic        d_denied;
  logic [63:0] d_data;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    input  a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, d_ready,
    output a_ready, d_valid, d_opcode, d_param, d_size, d_source, d_denied, d_data
  );
endinterface

// File: rtl/uart_fifo.sv
// 16550-style console UART on TileLink: TX/RX FIFOs, paced TX shifter, level irq; UART_DPI_EN adds sim console output.
// D response 1 cycle after A acceptance, one access in flight (a_ready low until d_ready); tx byte held until tx_ready.
module uart_fifo #(
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16,
  parameter int TX_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  uart_fifo_if.slave bus,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  input  logic       tx_ready,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       irq
);
  localparam int TAW = $clog2(TX_DEPTH);
  localparam int RAW = $clog2(RX_DEPTH);
  localparam int CW  = $clog2(TX_CYCLES + 1);
  localparam logic [2:0] TL_PUT_F           = 3'd0;
  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  state_t state, state_nxt;

  logic [1:0]  ier;
  logic [7:0]  lcr, scr, dll, dlm;
  logic [4:0]  mcr;
  logic        oe;
  logic [2:0]  d_opcode_q, d_size_q;
  logic [3:0]  d_source_q;
  logic [63:0] d_data_q;

  logic [7:0]     tx_mem [TX_DEPTH];
  logic [TAW-1:0] tx_wp, tx_rp;
  logic [TAW:0]   tx_cnt;
  logic [7:0]     rx_mem [RX_DEPTH];
  logic [RAW-1:0] rx_wp, rx_rp;
  logic [RAW:0]   rx_cnt;
  logic           sh_busy;
  logic [CW-1:0]  sh_cnt;

  logic       acc, rd, wr, dlab, dr, thre, temt;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_push, tx_pop, tx_clr, rx_push, rx_pop, rx_clr, oe_set;
  logic [2:0] off;
  logic [7:0] wd, rdata, lsr, iir;
  logic       unused_ok;

  assign off       = bus.a_address[2:0];
  assign wd        = bus.a_data[7:0];
  assign unused_ok = ^{bus.a_address[31:3], bus.a_data[63:8], bus.a_param, bus.a_mask};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    bus.a_ready = 1'b0;
    bus.d_valid = 1'b0;
    case (state)
      S_IDLE: begin
        bus.a_ready = 1'b1;
        if (bus.a_valid) state_nxt = S_BUSY;
      end
      S_BUSY: begin
        bus.d_valid = 1'b1;
        if (bus.d_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign acc  = bus.a_valid & (state == S_IDLE);
  assign rd   = acc & (bus.a_opcode == TL_GET);
  assign wr   = acc & (bus.a_opcode == TL_PUT_F);
  assign dlab = lcr[7];

  assign tx_empty = (tx_cnt == '0);
  assign tx_full  = (tx_cnt == (TAW+1)'(TX_DEPTH));
  assign rx_empty = (rx_cnt == '0);
  assign rx_full  = (rx_cnt == (RAW+1)'(RX_DEPTH));
  assign dr   = ~rx_empty;
  assign thre = tx_empty;
  assign temt = thre & ~sh_busy;
  assign lsr  = {1'b0, temt, thre, 3'b000, oe, dr};
  assign iir  = (ier[0] & dr) ? 8'hC4 : (ier[1] & thre) ? 8'hC2 : 8'hC1;
  assign irq  = (ier[0] & dr) | (ier[1] & thre);

  // A full FIFO still takes a push when the same cycle pops it; a clear beats everything.
  assign tx_clr  = wr & (off == 3'd2) & wd[2];
  assign rx_clr  = wr & (off == 3'd2) & wd[1];
  assign tx_pop  = ~sh_busy & ~tx_empty & ~tx_clr;
  assign tx_push = wr & (off == 3'd0) & ~dlab & (~tx_full | tx_pop);
  assign rx_pop  = rd & (off == 3'd0) & ~dlab & ~rx_empty;
  assign rx_push = rx_valid & (~rx_full | rx_pop) & ~rx_clr;
  assign oe_set  = rx_valid & rx_full & ~rx_pop & ~rx_clr;

  always_comb begin
    rdata = 8'h00;
    case (off)
      3'd0:    rdata = dlab ? dll : (rx_empty ? 8'h00 : rx_mem[rx_rp]);
      3'd1:    rdata = dlab ? dlm : {6'b0, ier};
      3'd2:    rdata = iir;
      3'd3:    rdata = lcr;
      3'd4:    rdata = {3'b0, mcr};
      3'd5:    rdata = lsr;
      3'd7:    rdata = scr;
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ier <= '0; lcr <= '0; mcr <= '0; scr <= '0; dll <= '0; dlm <= '0; oe <= 1'b0;
      d_opcode_q <= '0; d_size_q <= '0; d_source_q <= '0; d_data_q <= '0;
    end else begin
      if (acc) begin
        d_opcode_q <= (bus.a_opcode == TL_GET) ? TL_ACCESS_ACK_DATA : TL_ACCESS_ACK;
        d_size_q   <= bus.a_size;
        d_source_q <= bus.a_source;
        d_data_q   <= rd ? {56'b0, rdata} : 64'b0;
      end
      if (wr) begin
        case (off)
          3'd0:    if (dlab) dll <= wd;
          3'd1:    if (dlab) dlm <= wd; else ier <= wd[1:0];
          3'd3:    lcr <= wd;
          3'd4:    mcr <= wd[4:0];
          3'd7:    scr <= wd;
          default: ;
        endcase
      end
      // A fresh overrun wins over the clear-on-read of the same cycle.
      if (oe_set)                   oe <= 1'b1;
      else if (rd && off == 3'd5)   oe <= 1'b0;
    end
  end

  assign bus.d_opcode = d_opcode_q;
  assign bus.d_size   = d_size_q;
  assign bus.d_source = d_source_q;
  assign bus.d_data   = d_data_q;
  assign bus.d_param  = 2'b01;
  assign bus.d_denied = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
    end else if (tx_clr) begin
      tx_wp <= '0; tx_rp <= '0; tx_cnt <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      if (tx_push && !tx_pop)      tx_cnt <= tx_cnt + 1'b1;
      else if (!tx_push && tx_pop) tx_cnt <= tx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else if (rx_clr) begin
      rx_wp <= '0; rx_rp <= '0; rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      if (rx_push && !rx_pop)      rx_cnt <= rx_cnt + 1'b1;
      else if (!rx_push && rx_pop) rx_cnt <= rx_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= wd;
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  // Shifter: load on pop, count TX_CYCLES down, then present the byte until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_busy <= 1'b0; sh_cnt <= '0; tx_valid <= 1'b0; tx_data <= '0;
    end else if (tx_pop) begin
      sh_busy <= 1'b1;
      sh_cnt  <= CW'(TX_CYCLES);
      tx_data <= tx_mem[tx_rp];
    end else if (sh_busy && !tx_valid) begin
      sh_cnt <= sh_cnt - 1'b1;
      if (sh_cnt == CW'(1)) tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
      sh_busy  <= 1'b0;
    end
  end

`ifdef UART_DPI_EN
  always @(posedge clk) begin
    if (!rst && tx_valid && tx_ready) $display("%c", tx_data);
    if (acc && bus.a_opcode != TL_GET && bus.a_opcode != TL_PUT_F)
      $display("%0t Uart: opcode(%x)", $time, bus.a_opcode);
  end
`endif
endmodule

// File: tb/tb_uart_fifo.sv
// Self-checking bench for uart_fifo: register table, directed FIFO/irq/reset sequences, random run vs queue model.
module tb_uart_fifo;
  localparam int TXD = 16;
  localparam int RXD = 16;
  localparam int TXC = 4;
  localparam logic [2:0] GET = 3'd4, PUTF = 3'd0, PUTP = 3'd1, ARITH = 3'd2;
  localparam logic [2:0] ACK = 3'd0, ACKD = 3'd1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_fifo_if bus_if();
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       irq;

  uart_fifo #(.TX_DEPTH(TXD), .RX_DEPTH(RXD), .TX_CYCLES(TXC)) dut (
    .clk(clk), .rst(rst), .bus(bus_if),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .irq(irq)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [7:0] tx_got [$];
  int         tx_when[$];

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      tx_got.push_back(tx_data);
      tx_when.push_back(cyc);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Entered and left at posedge+1 with the bus idle; optionally strobes rx in the acceptance cycle.
  task automatic bus_op(input logic [2:0] op, input logic [2:0] addr, input logic [7:0] wd,
                        input bit rx_now, input logic [7:0] rx_b,
                        output logic [7:0] rd, output logic [2:0] dop);
    int n = 0;
    logic [3:0] src;
    src = 4'($urandom_range(0, 15));
    bus_if.a_valid   = 1'b1;
    bus_if.a_opcode  = op;
    bus_if.a_source  = src;
    bus_if.a_address = {29'b0, addr};
    bus_if.a_data    = {56'b0, wd};
    if (rx_now) begin rx_valid = 1'b1; rx_data = rx_b; end
    @(negedge clk);
    while (!bus_if.a_ready && n < 20) begin @(negedge clk); n++; end
    chk("a_ready", bus_if.a_ready, 1'b1);
    @(posedge clk); #1;
    bus_if.a_valid = 1'b0;
    rx_valid = 1'b0;
    @(negedge clk);
    chk("d_lat", bus_if.d_valid, 1'b1);
    chk("d_source", bus_if.d_source, src);
    chk("d_hi", bus_if.d_data[63:8], 56'b0);
    rd  = bus_if.d_data[7:0];
    dop = bus_if.d_opcode;
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] v);
    logic [7:0] r; logic [2:0] o;
    bus_op(PUTF, a, v, 1'b0, 8'h00, r, o);
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a, input logic [7:0] exp);
    logic [7:0] r; logic [2:0] o;
    bus_op(GET, a, 8'h00, 1'b0, 8'h00, r, o);
    chk(nm, r, exp);
  endtask

  task automatic rd_val(input logic [2:0] a, output logic [7:0] r);
    logic [2:0] o;
    bus_op(GET, a, 8'h00, 1'b0, 8'h00, r, o);
  endtask

  task automatic rx_strobe(input logic [7:0] b);
    rx_valid = 1'b1; rx_data = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while (tx_got.size() < n && k < budget) begin tick(); k++; end
    chk("tx_wait", 64'(tx_got.size() >= n), 1);
  endtask

  typedef struct {
    logic [2:0] op; logic [2:0] addr; logic [7:0] wd;
    logic [2:0] eop; logic [7:0] edat; logic eirq;
  } vec_t;
  vec_t vt[$];

  function automatic void add(input logic [2:0] op, input logic [2:0] a, input logic [7:0] wd,
                              input logic [2:0] eop, input logic [7:0] ed, input logic ei);
    vec_t v;
    v.op = op; v.addr = a; v.wd = wd; v.eop = eop; v.edat = ed; v.eirq = ei;
    vt.push_back(v);
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r;
    logic [2:0] o;
    logic [7:0] rx_q[$];
    logic [7:0] tx_exp[$];
    logic       m_oe, m_ier0;
    logic [7:0] m_scr, m_lcr;

    bus_if.a_valid = 1'b0; bus_if.a_opcode = 3'd0; bus_if.a_param = 3'd0; bus_if.a_size = 3'd3;
    bus_if.a_source = 4'd0; bus_if.a_address = 32'd0; bus_if.a_mask = 8'hFF; bus_if.a_data = 64'd0;
    bus_if.d_ready = 1'b1;

    #12;
    chk("rst_a_ready", bus_if.a_ready, 1'b1);
    chk("rst_d_valid", bus_if.d_valid, 1'b0);
    chk("rst_d_data", bus_if.d_data, 64'd0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_irq", irq, 1'b0);
    chk("d_param", bus_if.d_param, 2'b01);
    chk("d_denied", bus_if.d_denied, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    tick();

    add(GET, 3'd5, 8'h00, ACKD, 8'h60, 1'b0);
    add(GET, 3'd1, 8'h00, ACKD, 8'h00, 1'b0);
    add(GET, 3'd2, 8'h00, ACKD, 8'hC1, 1'b0);
    add(GET, 3'd3, 8'h00, ACKD, 8'h00, 1'b0);
    add(GET, 3'd4, 8'h00, ACKD, 8'h00, 1'b0);
    add(GET, 3'd6, 8'h00, ACKD, 8'h00, 1'b0);
    add(GET, 3'd7, 8'h00, ACKD, 8'h00, 1'b0);
    add(PUTF, 3'd7, 8'hA5, ACK, 8'h00, 1'b0);
    add(GET, 3'd7, 8'h00, ACKD, 8'hA5, 1'b0);
    add(PUTF, 3'd4, 8'hFF, ACK, 8'h00, 1'b0);
    add(GET, 3'd4, 8'h00, ACKD, 8'h1F, 1'b0);
    add(PUTF, 3'd1, 8'hFF, ACK, 8'h00, 1'b1);
    add(GET, 3'd1, 8'h00, ACKD, 8'h03, 1'b1);
    add(GET, 3'd2, 8'h00, ACKD, 8'hC2, 1'b1);
    add(PUTF, 3'd1, 8'h00, ACK, 8'h00, 1'b0);
    add(PUTF, 3'd6, 8'h55, ACK, 8'h00, 1'b0);
    add(GET, 3'd6, 8'h00, ACKD, 8'h00, 1'b0);
    add(PUTF, 3'd5, 8'h00, ACK, 8'h00, 1'b0);
    add(GET, 3'd5, 8'h00, ACKD, 8'h60, 1'b0);
    add(PUTP, 3'd7, 8'h11, ACK, 8'h00, 1'b0);
    add(GET, 3'd7, 8'h00, ACKD, 8'hA5, 1'b0);
    add(ARITH, 3'd3, 8'hFF, ACK, 8'h00, 1'b0);
    add(GET, 3'd3, 8'h00, ACKD, 8'h00, 1'b0);
    add(PUTF, 3'd3, 8'h80, ACK, 8'h00, 1'b0);
    add(PUTF, 3'd0, 8'h1B, ACK, 8'h00, 1'b0);
    add(PUTF, 3'd1, 8'h00, ACK, 8'h00, 1'b0);
    add(GET, 3'd0, 8'h00, ACKD, 8'h1B, 1'b0);
    add(GET, 3'd1, 8'h00, ACKD, 8'h00, 1'b0);
    add(PUTF, 3'd1, 8'h5C, ACK, 8'h00, 1'b0);
    add(GET, 3'd1, 8'h00, ACKD, 8'h5C, 1'b0);
    add(GET, 3'd3, 8'h00, ACKD, 8'h80, 1'b0);
    add(PUTF, 3'd3, 8'h03, ACK, 8'h00, 1'b0);
    add(GET, 3'd1, 8'h00, ACKD, 8'h00, 1'b0);
    add(GET, 3'd3, 8'h00, ACKD, 8'h03, 1'b0);
    add(GET, 3'd0, 8'h00, ACKD, 8'h00, 1'b0);
    add(PUTF, 3'd3, 8'h00, ACK, 8'h00, 1'b0);

    for (int i = 0; i < vt.size(); i++) begin
      bus_op(vt[i].op, vt[i].addr, vt[i].wd, 1'b0, 8'h00, r, o);
      chk($sformatf("vec%0d_op", i), o, vt[i].eop);
      chk($sformatf("vec%0d_dat", i), r, vt[i].edat);
      chk($sformatf("vec%0d_irq", i), irq, vt[i].eirq);
    end

    // Paced transmit of three bytes
    tx_ready = 1'b1;
    tx_got.delete(); tx_when.delete();
    wr(3'd0, 8'h41); wr(3'd0, 8'h42); wr(3'd0, 8'h43);
    rd_chk("lsr_tx_busy", 3'd5, 8'h00);
    wait_tx(3, 200);
    if (tx_got.size() >= 3) begin
      chk("tx_b0", tx_got[0], 8'h41);
      chk("tx_b1", tx_got[1], 8'h42);
      chk("tx_b2", tx_got[2], 8'h43);
      chk("tx_gap1", 64'((tx_when[1] - tx_when[0]) >= TXC), 1);
      chk("tx_gap2", 64'((tx_when[2] - tx_when[1]) >= TXC), 1);
    end
    tick(2);
    rd_chk("lsr_tx_done", 3'd5, 8'h60);

    // Fill with a stalled sink: one byte parks in the shifter, the last write is dropped
    tx_ready = 1'b0;
    tx_got.delete(); tx_when.delete();
    for (int i = 0; i < TXD + 2; i++) wr(3'd0, 8'(8'h80 + i));
    rd_chk("lsr_tx_full", 3'd5, 8'h00);
    tx_ready = 1'b1;
    wait_tx(TXD + 1, 2000);
    tick(50);
    chk("fill_count", tx_got.size(), TXD + 1);
    for (int i = 0; i < TXD + 1 && i < tx_got.size(); i++)
      chk($sformatf("fill_b%0d", i), tx_got[i], 8'(8'h80 + i));

    // TX FIFO clear while the shifter holds a byte
    tx_ready = 1'b0;
    tx_got.delete(); tx_when.delete();
    for (int i = 0; i < 5; i++) wr(3'd0, 8'(8'h10 + i));
    wr(3'd2, 8'h04);
    rd_chk("lsr_fcr_tx", 3'd5, 8'h20);
    tx_ready = 1'b1;
    tick(60);
    chk("fcr_count", tx_got.size(), 1);
    if (tx_got.size() > 0) chk("fcr_b0", tx_got[0], 8'h10);
    rd_chk("lsr_fcr_done", 3'd5, 8'h60);

    // RX data interrupt
    wr(3'd1, 8'h01);
    rx_strobe(8'h5A);
    chk("irq_rx", irq, 1'b1);
    rd_chk("iir_rx", 3'd2, 8'hC4);
    rd_chk("lsr_rx", 3'd5, 8'h61);
    rd_chk("rbr_5a", 3'd0, 8'h5A);
    chk("irq_clr", irq, 1'b0);
    rd_chk("iir_none", 3'd2, 8'hC1);

    // RX overrun, sticky OE cleared by reading LSR
    for (int i = 0; i < RXD + 1; i++) rx_strobe(8'(8'h30 + i));
    chk("irq_full", irq, 1'b1);
    rd_chk("lsr_oe", 3'd5, 8'h63);
    rd_chk("lsr_oe_clr", 3'd5, 8'h61);
    for (int i = 0; i < RXD; i++) rd_chk($sformatf("rbr_ov%0d", i), 3'd0, 8'(8'h30 + i));
    rd_chk("rbr_empty", 3'd0, 8'h00);
    rd_chk("lsr_rx_empty", 3'd5, 8'h60);

    // Push and pop together while full: both succeed, no overrun
    for (int i = 0; i < RXD; i++) rx_strobe(8'(8'h50 + i));
    bus_op(GET, 3'd0, 8'h00, 1'b1, 8'hEE, r, o);
    chk("rbr_pp", r, 8'h50);
    rd_chk("lsr_pp", 3'd5, 8'h61);
    for (int i = 1; i < RXD; i++) rd_chk($sformatf("rbr_pp%0d", i), 3'd0, 8'(8'h50 + i));
    rd_chk("rbr_pp_new", 3'd0, 8'hEE);
    rd_chk("lsr_pp_done", 3'd5, 8'h60);

    // FCR RX clear beats a same-cycle push into a full FIFO: byte lost, OE untouched
    for (int i = 0; i < RXD; i++) rx_strobe(8'(8'h60 + i));
    bus_op(PUTF, 3'd2, 8'h02, 1'b1, 8'h88, r, o);
    rd_chk("lsr_fcr_rx", 3'd5, 8'h60);
    rd_chk("rbr_fcr_rx", 3'd0, 8'h00);

    // Random mix against a queue model
    wr(3'd1, 8'h00);
    tx_ready = 1'b1;
    tx_got.delete(); tx_when.delete();
    m_oe = 1'b0; m_ier0 = 1'b0; m_scr = 8'hA5; m_lcr = 8'h00;
    for (int it = 0; it < 400; it++) begin
      logic [7:0] b;
      b = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 9))
        0, 1: begin
          rx_strobe(b);
          if (rx_q.size() < RXD) rx_q.push_back(b); else m_oe = 1'b1;
        end
        2: rd_chk("rnd_rbr", 3'd0, (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00);
        3: begin
          rd_val(3'd5, r);
          chk("rnd_lsr", r & 8'h03, {6'b0, m_oe, 1'(rx_q.size() > 0)});
          m_oe = 1'b0;
        end
        4: begin
          rd_chk("rnd_iir", 3'd2, (m_ier0 && rx_q.size() > 0) ? 8'hC4 : 8'hC1);
          chk("rnd_irq", irq, 1'(m_ier0 && rx_q.size() > 0));
        end
        5: begin wr(3'd7, b); m_scr = b; end
        6: rd_chk("rnd_scr", 3'd7, m_scr);
        7: begin
          if (tx_exp.size() - tx_got.size() < TXD) begin
            wr(3'd0, b); tx_exp.push_back(b);
          end else rd_chk("rnd_lcr", 3'd3, m_lcr);
        end
        8: begin m_ier0 = b[0]; wr(3'd1, {7'b0, b[0]}); end
        default: begin
          if (b[1:0] == 2'b00) begin wr(3'd2, 8'h02); rx_q.delete(); end
          else begin
            m_lcr = b & 8'h7F; wr(3'd3, m_lcr);
            rd_chk("rnd_lcr_rb", 3'd3, m_lcr);
          end
        end
      endcase
    end
    wait_tx(tx_exp.size(), 5000);
    chk("rnd_tx_count", tx_got.size(), tx_exp.size());
    for (int i = 0; i < tx_exp.size() && i < tx_got.size(); i++)
      chk($sformatf("rnd_tx%0d", i), tx_got[i], tx_exp[i]);

    // Reset in the middle of a response with a byte waiting on the TX port
    wr(3'd3, 8'h80); wr(3'd0, 8'h12); wr(3'd1, 8'h34); wr(3'd3, 8'h03);
    wr(3'd7, 8'h5A); wr(3'd4, 8'h07); wr(3'd1, 8'h03);
    tx_ready = 1'b0;
    wr(3'd0, 8'h99);
    tick(TXC + 3);
    chk("tx_pre_rst", tx_valid, 1'b1);
    rx_strobe(8'h11);
    bus_if.a_valid = 1'b1; bus_if.a_opcode = GET; bus_if.a_address = 32'd7;
    @(posedge clk); #1;
    bus_if.a_valid = 1'b0;
    @(negedge clk);
    chk("busy_pre_rst", bus_if.d_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_mid_d_valid", bus_if.d_valid, 1'b0);
    chk("rst_mid_tx_valid", tx_valid, 1'b0);
    chk("rst_mid_tx_data", tx_data, 8'h00);
    chk("rst_mid_irq", irq, 1'b0);
    chk("rst_mid_a_ready", bus_if.a_ready, 1'b1);
    tick(2);
    rst = 1'b0;
    tx_got.delete(); tx_when.delete();
    tx_ready = 1'b1;
    tick();
    rd_chk("post_lsr", 3'd5, 8'h60);
    rd_chk("post_ier", 3'd1, 8'h00);
    rd_chk("post_iir", 3'd2, 8'hC1);
    rd_chk("post_lcr", 3'd3, 8'h00);
    rd_chk("post_mcr", 3'd4, 8'h00);
    rd_chk("post_scr", 3'd7, 8'h00);
    rd_chk("post_rbr", 3'd0, 8'h00);
    wr(3'd3, 8'h80);
    rd_chk("post_dll", 3'd0, 8'h00);
    rd_chk("post_dlm", 3'd1, 8'h00);
    wr(3'd3, 8'h00);
    tick(20);
    chk("post_no_tx", tx_got.size(), 0);
    chk("post_irq", irq, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
